ps2_scancode_rx: RTL and testbench

Receives the raw PS/2 keyboard clock/data lines, deserialises 11-bit frames, and decodes make/break/extended prefixes. It emits a single-cycle `ps2_key_pressed` strobe with the scancode, and a matching release strobe. It sits directly upstream of the key-press hold/repeat stage, which consumes `ps2_key_pressed` and stretches it by the game speed factor.

---
 rtl/ps2_scancode_rx.sv | 175 +++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// Purpose : PS/2 keyboard receiver; conditions the raw lines, deserialises 11-bit frames, decodes E0/F0 prefixes.
// Latency : strobes appear 2 (sync) + FILTER_LEN + 1 cycles after the raw stop-bit falling edge.
// Backpressure: none; all outputs are one-cycle strobes or held levels, the consumer must take them as they come.
//
// Ports:
//   clock, resetn              system clock (rising edge), asynchronous active-low reset
//   ps2_clk, ps2_data          raw asynchronous PS/2 lines from the connector
//   ps2_key_pressed/_released  one-cycle make / break strobes (never together)
//   ps2_key_data/_extended     scancode and E0 flag of the last make/break, held
//   byte_valid, byte_data      strobe for every good byte (prefixes included), last good byte held
//   frame_error                one-cycle strobe on bad start/parity/stop or mid-frame timeout
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_key_pressed,
    output logic       ps2_key_released,
    output logic [7:0] ps2_key_data,
    output logic       ps2_key_extended,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);

    // Line conditioning; index 0 is ps2_clk, index 1 is ps2_data.
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      filt;
    logic [1:0][3:0] fcnt;
    logic            clk_prev;

    logic            fall;
    logic            sample;

    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_ok;
    logic [TW-1:0]   to_cnt;
    logic            ext_flag;
    logic            brk_flag;

    // Synchronisers and filters idle high so reset never fabricates a falling edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_a   <= 2'b11;
            sync_b   <= 2'b11;
            filt     <= 2'b11;
            fcnt     <= '0;
            clk_prev <= 1'b1;
        end else begin
            sync_a   <= {ps2_data, ps2_clk};
            sync_b   <= sync_a;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                // Count consecutive samples disagreeing with the filtered level;
                // the FILTER_LEN-th one flips it, any agreeing sample restarts the count.
                if (sync_b[i] != filt[i]) begin
                    if (fcnt[i] == FL_LAST) begin
                        filt[i] <= sync_b[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 4'd1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    assign fall   = clk_prev & ~filt[0];
    assign sample = filt[1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state            <= ST_IDLE;
            bit_cnt          <= '0;
            shreg            <= '0;
            par_ok           <= 1'b0;
            to_cnt           <= '0;
            ext_flag         <= 1'b0;
            brk_flag         <= 1'b0;
            ps2_key_pressed  <= 1'b0;
            ps2_key_released <= 1'b0;
            ps2_key_data     <= '0;
            ps2_key_extended <= 1'b0;
            byte_valid       <= 1'b0;
            byte_data        <= '0;
            frame_error      <= 1'b0;
        end else begin
            ps2_key_pressed  <= 1'b0;
            ps2_key_released <= 1'b0;
            byte_valid       <= 1'b0;
            frame_error      <= 1'b0;

            if (fall) begin
                to_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!sample) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_error <= 1'b1;
                            ext_flag    <= 1'b0;
                            brk_flag    <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {sample, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_ok <= (^shreg) ^ sample;
                        state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (sample && par_ok) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                            if (shreg == 8'hE0) begin
                                ext_flag <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk_flag <= 1'b1;
                            end else begin
                                ps2_key_pressed  <= ~brk_flag;
                                ps2_key_released <= brk_flag;
                                ps2_key_data     <= shreg;
                                ps2_key_extended <= ext_flag;
                                ext_flag         <= 1'b0;
                                brk_flag         <= 1'b0;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            ext_flag    <= 1'b0;
                            brk_flag    <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                // Keyboard stopped clocking mid-frame: abandon it and any pending prefix.
                if (to_cnt == TO_LAST) begin
                    state       <= ST_IDLE;
                    shreg       <= '0;
                    to_cnt      <= '0;
                    frame_error <= 1'b1;
                    ext_flag    <= 1'b0;
                    brk_flag    <= 1'b0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

    localparam int FL   = 4;
    localparam int TO   = 300;
    localparam int HALF = 20;

    localparam logic [1:0] K_BYTE  = 2'd0;
    localparam logic [1:0] K_PRESS = 2'd1;
    localparam logic [1:0] K_REL   = 2'd2;
    localparam logic [1:0] K_ERR   = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] b;
        logic       ext;
    } ev_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ps2_key_pressed;
    logic       ps2_key_released;
    logic [7:0] ps2_key_data;
    logic       ps2_key_extended;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_error;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .ps2_clk          (ps2_clk),
        .ps2_data         (ps2_data),
        .ps2_key_pressed  (ps2_key_pressed),
        .ps2_key_released (ps2_key_released),
        .ps2_key_data     (ps2_key_data),
        .ps2_key_extended (ps2_key_extended),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .frame_error      (frame_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_fall_cyc = 0;
    int bv_cyc   = 0;
    int n_press  = 0;
    int n_rel    = 0;

    ev_t        exp_q[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] hold_key  = 8'h00;
    logic       hold_ext  = 1'b0;
    logic [7:0] hold_byte = 8'h00;

    always @(posedge clock) cyc++;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Decoder behaviour expressed as events in arrival order.
    task automatic model_frame(input logic [7:0] b, input bit ok);
        ev_t e;
        e.b   = b;
        e.ext = m_ext;
        if (!ok) begin
            e.kind = K_ERR;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            e.kind = K_BYTE;
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            e.kind = K_BYTE;
            m_brk = 1'b1;
        end else begin
            e.kind = m_brk ? K_REL : K_PRESS;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par_flip, input bit stop);
        return {stop, (~^b) ^ par_flip, b, 1'b0};
    endfunction

    task automatic send_raw(input logic [10:0] bits, input int nbits, input int glitch);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (glitch > 0) begin
                wait_cyc(8);
                ps2_clk = 1'b0;
                wait_cyc(glitch);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 8 - glitch);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) wait_cyc(1);
        check(exp_q.size() == 0, "drain_pending", exp_q.size(), 0);
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop, input int glitch);
        model_frame(b, !par_flip && stop);
        send_raw(frame_bits(b, par_flip, stop), 11, glitch);
        drain(100);
    endtask

    // Per-cycle comparison of the DUT against the event model.
    always @(negedge clock) begin
        if (!resetn) begin
            check({ps2_key_pressed, ps2_key_released, ps2_key_data, ps2_key_extended,
                   byte_valid, byte_data, frame_error} == '0, "reset_outputs",
                  {ps2_key_data, byte_data}, 0);
            hold_key  = 8'h00;
            hold_ext  = 1'b0;
            hold_byte = 8'h00;
        end else begin
            ev_t e;
            check(!(ps2_key_pressed && ps2_key_released), "press_rel_exclusive",
                  {ps2_key_pressed, ps2_key_released}, 0);
            if (ps2_key_pressed) n_press++;
            if (ps2_key_released) n_rel++;
            if (byte_valid) bv_cyc = cyc;
            if (byte_valid || frame_error || ps2_key_pressed || ps2_key_released) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_strobe",
                          {byte_valid, frame_error, ps2_key_pressed, ps2_key_released}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(frame_error == (e.kind == K_ERR), "frame_error", frame_error, e.kind == K_ERR);
                    check(byte_valid == (e.kind != K_ERR), "byte_valid", byte_valid, e.kind != K_ERR);
                    check(ps2_key_pressed == (e.kind == K_PRESS), "pressed", ps2_key_pressed, e.kind == K_PRESS);
                    check(ps2_key_released == (e.kind == K_REL), "released", ps2_key_released, e.kind == K_REL);
                    if (e.kind != K_ERR) hold_byte = e.b;
                    if (e.kind == K_PRESS || e.kind == K_REL) begin
                        hold_key = e.b;
                        hold_ext = e.ext;
                    end
                end
            end
            check(byte_data == hold_byte, "byte_data", byte_data, hold_byte);
            check(ps2_key_data == hold_key, "key_data", ps2_key_data, hold_key);
            check(ps2_key_extended == hold_ext, "key_extended", ps2_key_extended, hold_ext);
        end
    end

    initial begin
        #2 resetn = 1'b0;
        wait_cyc(5);
        resetn = 1'b1;
        wait_cyc(20);

        // Plain make code.
        send_frame(8'h1D, 1'b0, 1'b1, 0);
        check(ps2_key_data == 8'h1D, "lit_1d_data", ps2_key_data, 8'h1D);
        check(ps2_key_extended == 1'b0, "lit_1d_ext", ps2_key_extended, 0);
        check(n_press == 1 && n_rel == 0, "lit_1d_counts", {n_press[15:0], n_rel[15:0]}, 32'h0001_0000);
        check((bv_cyc - last_fall_cyc) >= 6 && (bv_cyc - last_fall_cyc) <= 8, "latency",
              bv_cyc - last_fall_cyc, 2 + FL + 1);

        // Break sequence.
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h1D, 1'b0, 1'b1, 0);
        check(n_press == 1 && n_rel == 1, "lit_break_counts", {n_press[15:0], n_rel[15:0]}, 32'h0001_0001);

        // Extended make then extended break.
        send_frame(8'hE0, 1'b0, 1'b1, 0);
        send_frame(8'h75, 1'b0, 1'b1, 0);
        check(ps2_key_data == 8'h75 && ps2_key_extended, "lit_ext_make", {ps2_key_extended, ps2_key_data}, 9'h175);
        send_frame(8'hE0, 1'b0, 1'b1, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h75, 1'b0, 1'b1, 0);
        check(n_press == 2 && n_rel == 2, "lit_ext_counts", {n_press[15:0], n_rel[15:0]}, 32'h0002_0002);

        // Parity error after a break prefix must drop the prefix and keep held key data.
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h1D, 1'b1, 1'b1, 0);
        check(ps2_key_data == 8'h75, "lit_err_keeps_data", ps2_key_data, 8'h75);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check(n_press == 3 && n_rel == 2, "lit_after_err", {n_press[15:0], n_rel[15:0]}, 32'h0003_0002);

        // Bad stop bit, then bad start bit (single clock pulse with data high).
        send_frame(8'h1D, 1'b0, 1'b0, 0);
        model_frame(8'h00, 1'b0);
        send_raw(11'h7FF, 1, 0);
        drain(100);

        // Timeout after 5 data bits following a break prefix.
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        model_frame(8'h00, 1'b0);
        send_raw(frame_bits(8'h1D, 1'b0, 1'b1), 6, 0);
        wait_cyc(TO - 60);
        check(exp_q.size() == 1, "timeout_not_early", exp_q.size(), 1);
        drain(200);
        send_frame(8'h1D, 1'b0, 1'b1, 0);
        check(n_press == 4 && n_rel == 2, "lit_after_timeout", {n_press[15:0], n_rel[15:0]}, 32'h0004_0002);

        // Clock glitches one cycle shorter than the filter, then typematic repeats.
        send_frame(8'h1C, 1'b0, 1'b1, FL - 1);
        send_frame(8'h1C, 1'b0, 1'b1, 1);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check(ps2_key_data == 8'h1C, "lit_glitch_data", ps2_key_data, 8'h1C);
        check(n_press == 7, "lit_typematic", n_press, 7);

        // Reset asserted mid-frame, then a clean frame.
        send_raw(frame_bits(8'h2A, 1'b0, 1'b1), 4, 0);
        wait_cyc(3);
        resetn = 1'b0;
        #2;
        check({ps2_key_pressed, ps2_key_released, ps2_key_data, ps2_key_extended,
               byte_valid, byte_data, frame_error} == '0, "async_reset",
              {ps2_key_data, byte_data}, 0);
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        resetn = 1'b1;
        wait_cyc(20);
        send_frame(8'h2A, 1'b0, 1'b1, 0);
        check(ps2_key_data == 8'h2A && !ps2_key_extended, "lit_after_reset",
              {ps2_key_extended, ps2_key_data}, 9'h02A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
